// File: rtl/memory_pkg.sv
// Shared CPU memory definitions: loader FSM state encoding and the
// program start address that the CPU fetch path relies on.
package memory_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // First word written by the program loader; the CPU starts fetching here.
  localparam int LOAD_BASE = 8;

endpackage

// File: rtl/memory_ram_sp.sv
// Single-port RAM: synchronous write, registered read, write-first.
// The array itself has no reset; only the read register is cleared.
module ram_sp #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; a write in the same cycle is returned directly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_we) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory.sv
// CPU program memory with a power-up sequencer: zero the whole array,
// accept a program stream from the loader, then hand the port to the CPU.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | clear counter writes 0 to every address, one word per cycle
// LOAD  | ld_ready=1; each accepted loader word goes to the load pointer
// RUN   | CPU owns the RAM port; terminal until rst
module memory #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = memory_pkg::LOAD_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  overflow
);

  import memory_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(LOAD_BASE);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] r_ld_ptr;
  logic                  r_ld_ready;
  logic                  r_busy;
  logic                  r_overflow;
  logic                  r_rd_en;

  logic                  w_accept;
  logic                  w_ld_at_top;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_accept    = r_ld_ready & ld_valid;
  assign w_ld_at_top = (r_ld_ptr == TOP_ADDR);

  // Sequencer FSM with registered ld_ready/busy/overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_ld_ptr   <= BASE_ADDR;
      r_ld_ready <= 1'b0;
      r_busy     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == TOP_ADDR) begin
            r_state    <= LOAD;
            r_ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            // Pointer parks at the top address rather than wrapping to 0.
            if (!w_ld_at_top) begin
              r_ld_ptr <= r_ld_ptr + 1'b1;
            end
            if (ld_last || w_ld_at_top) begin
              r_state    <= RUN;
              r_ld_ready <= 1'b0;
              r_busy     <= 1'b0;
            end
            if (!ld_last && w_ld_at_top) begin
              r_overflow <= 1'b1;
            end
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state    <= CLEAR;
          r_clr_cnt  <= '0;
          r_ld_ptr   <= BASE_ADDR;
          r_ld_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  // Read data is only exposed for accesses issued while in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= (r_state == RUN);
    end
  end

  // RAM port ownership follows the sequencer state.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_clr_cnt;
    w_ram_wdata = '0;
    case (r_state)
      CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_clr_cnt;
        w_ram_wdata = '0;
      end
      LOAD: begin
        w_ram_we    = w_accept;
        w_ram_addr  = r_ld_ptr;
        w_ram_wdata = ld_data;
      end
      RUN: begin
        w_ram_we    = we;
        w_ram_addr  = addr;
        w_ram_wdata = data;
      end
      default: begin
        w_ram_we = 1'b0;
      end
    endcase
    // Holding rst must not disturb stored contents.
    if (rst) begin
      w_ram_we = 1'b0;
    end
  end

  ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign out      = r_rd_en ? w_ram_rdata : '0;
  assign ld_ready = r_ld_ready;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_memory.sv
// Bench for memory: behavioural model of the array and loader, with a
// queue-based scoreboard checking CPU reads in RUN.
module tb_memory;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int BASE  = 8;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW-1:0] out;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          busy;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem_m [DEPTH];
  int            ld_ptr_m;
  bit            ov_m;

  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  logic [DW-1:0] mon_exp;
  string         mon_name;
  int            ncyc;

  memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOAD_BASE (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .data    (data),
    .out     (out),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .busy    (busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: each access issued in RUN yields one output a cycle later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      chk(mon_name, out, mon_exp);
    end
  end

  task automatic model_clear();
    foreach (mem_m[i]) mem_m[i] = '0;
    ld_ptr_m = BASE;
    ov_m     = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (ld_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    we = 1'b0;
    ld_valid = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(ncyc);
    chk("clear cycle count", ncyc, 64);
  endtask

  task automatic load_word(input logic [DW-1:0] d, input bit last);
    bit done;
    @(negedge clk);
    chk("ld_ready in LOAD", ld_ready, 1);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    mem_m[ld_ptr_m] = d;
    done = last || (ld_ptr_m == DEPTH - 1);
    if (!last && ld_ptr_m == DEPTH - 1) ov_m = 1'b1;
    if (!done) ld_ptr_m++;
    chk("busy after loader word", busy, done ? 0 : 1);
    chk("overflow after loader word", overflow, ov_m);
  endtask

  task automatic idle_ld();
    @(negedge clk);
    ld_valid = 1'b0;
    ld_data  = DW'($urandom);
    ld_last  = 1'($urandom);
  endtask

  task automatic rd(input int a);
    @(negedge clk);
    we   = 1'b0;
    addr = AW'(a);
    data = DW'($urandom);
    exp_q.push_back(mem_m[a]);
    name_q.push_back($sformatf("read[%0d]", a));
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = AW'(a);
    data = d;
    mem_m[a] = d;
    exp_q.push_back(d);
    name_q.push_back($sformatf("write-first[%0d]", a));
  endtask

  task automatic drain();
    int k;
    @(negedge clk);
    we = 1'b0;
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
    name_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; data = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1);
    chk("reset ld_ready", ld_ready, 0);
    chk("reset out", out, 0);
    chk("reset overflow", overflow, 0);
    rst = 1'b0;
    wait_clear(ncyc);
    chk("clear cycle count", ncyc, 64);
    chk("busy in LOAD", busy, 1);
    chk("out in LOAD", out, 0);

    // Single zero word: whole array must read back as zero.
    load_word(16'h0000, 1'b1);
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();

    // Three-word program.
    restart();
    load_word(16'h1234, 1'b0);
    load_word(16'hABCD, 1'b0);
    load_word(16'h0F0F, 1'b1);
    chk("ld_ready in RUN", ld_ready, 0);
    for (int a = 7; a < 12; a++) rd(a);

    // Write-first, then hold, then a neighbouring address.
    wr(5, 16'h00FF);
    rd(5);
    rd(6);
    drain();

    // Random CPU traffic against the model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      else rd(int'($urandom_range(0, DEPTH - 1)));
    end
    drain();

    // Loader inputs ignored once in RUN.
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 16'hFFFF; ld_last = 1'b1;
    chk("ld_ready ignored in RUN", ld_ready, 0);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    rd(11);
    rd(BASE);
    drain();

    // Asynchronous reset from RUN clears out immediately.
    wr(20, 16'hA5A5);
    @(negedge clk);
    we = 1'b0; addr = 6'd20;
    @(posedge clk);
    #3;
    chk("out before rst in RUN", out, 16'hA5A5);
    rst = 1'b1;
    #1;
    chk("out on rst in RUN", out, 0);
    chk("busy on rst in RUN", busy, 1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(ncyc);
    chk("clear cycle count after RUN rst", ncyc, 64);

    // Gapped loader valid: 1,0,0,1.
    load_word(16'h1111, 1'b0);
    idle_ld();
    idle_ld();
    load_word(16'h2222, 1'b1);
    for (int a = 7; a < 12; a++) rd(a);
    drain();

    // Reset after 2 of 4 loader words; reload one word.
    restart();
    load_word(16'hDEAD, 1'b0);
    load_word(16'hBEEF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("busy on mid-load rst", busy, 1);
    chk("out on mid-load rst", out, 0);
    chk("ld_ready on mid-load rst", ld_ready, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    wait_clear(ncyc);
    chk("clear cycle count after LOAD rst", ncyc, 64);
    load_word(16'h7E57, 1'b1);
    for (int a = BASE; a < BASE + 4; a++) rd(a);
    drain();

    // Overflow: 56 words without ld_last fill 8..63.
    restart();
    for (int i = 0; i < DEPTH - BASE; i++) load_word(DW'($urandom), 1'b0);
    chk("overflow set", overflow, 1);
    chk("busy after overflow", busy, 0);
    chk("ld_ready after overflow", ld_ready, 0);
    for (int a = 0; a < DEPTH; a++) rd(a);
    wr(3, 16'h0303);
    rd(3);
    drain();
    chk("overflow sticky", overflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
